// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: pipelined IEEE-754-style floating-point adder/subtractor with valid/ready streaming.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results are truncated (round toward zero)
// and overflow saturates to the largest finite value.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int AW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [EXP_W-1:0] EMAXM1 = EMAX - EXP_W'(1);
  localparam logic [W-1:0]     QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  logic v1, v2, v3, v4;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic             sa, sb, za, zb, ia, ib, na, nb, a_ge;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;
  logic             c1_sp, c1_inv;
  logic [W-1:0]     c1_res;

  assign sa   = a[W-1];
  assign sb   = b[W-1] ^ sub;
  assign ea   = a[W-2:MAN_W];
  assign eb   = b[W-2:MAN_W];
  assign za   = (ea == '0);
  assign zb   = (eb == '0);
  assign ia   = (ea == EMAX) && (a[MAN_W-1:0] == '0);
  assign ib   = (eb == EMAX) && (b[MAN_W-1:0] == '0);
  assign na   = (ea == EMAX) && (a[MAN_W-1:0] != '0);
  assign nb   = (eb == EMAX) && (b[MAN_W-1:0] != '0);
  assign ma   = za ? '0 : {1'b1, a[MAN_W-1:0]};
  assign mb   = zb ? '0 : {1'b1, b[MAN_W-1:0]};
  assign a_ge = {ea, ma} >= {eb, mb};

  // Special operands (NaN, inf) decide the result up front; it rides the pipe beside the datapath.
  always_comb begin
    c1_sp  = 1'b0;
    c1_inv = 1'b0;
    c1_res = QNAN;
    if (na || nb) begin
      c1_sp  = 1'b1;
      c1_inv = (na && !a[MAN_W-1]) || (nb && !b[MAN_W-1]);
    end else if (ia && ib && (sa != sb)) begin
      c1_sp  = 1'b1;
      c1_inv = 1'b1;
    end else if (ia) begin
      c1_sp  = 1'b1;
      c1_res = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (ib) begin
      c1_sp  = 1'b1;
      c1_res = {sb, EMAX, {MAN_W{1'b0}}};
    end
  end

  logic             s1_xs, s1_ys, s1_sp, s1_inv;
  logic [EXP_W-1:0] s1_xe, s1_ye;
  logic [MAN_W:0]   s1_xm, s1_ym;
  logic [W-1:0]     s1_res;

  // Stage 1 register: larger magnitude operand becomes X, subnormals already forced to zero.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_xs  <= a_ge ? sa : sb;
      s1_ys  <= a_ge ? sb : sa;
      s1_xe  <= a_ge ? ea : eb;
      s1_ye  <= a_ge ? eb : ea;
      s1_xm  <= a_ge ? ma : mb;
      s1_ym  <= a_ge ? mb : ma;
      s1_sp  <= c1_sp;
      s1_inv <= c1_inv;
      s1_res <= c1_res;
    end
  end

  logic [EXP_W-1:0] diff;
  logic [AW-1:0]    y_ext, y_aln;
  logic             lost;

  assign diff  = s1_xe - s1_ye;
  assign y_ext = {s1_ym, 3'b000};
  assign lost  = |(y_ext & ~({AW{1'b1}} << diff));
  assign y_aln = (y_ext >> diff) | {{(AW-1){1'b0}}, lost};

  logic             s2_xs, s2_ys, s2_sp, s2_inv;
  logic [EXP_W-1:0] s2_xe;
  logic [AW-1:0]    s2_x, s2_y;
  logic [W-1:0]     s2_res;

  // Stage 2 register: Y aligned to X with guard/round/sticky below the fraction.
  always_ff @(posedge clk) begin
    if (en) begin
      s2_xs  <= s1_xs;
      s2_ys  <= s1_ys;
      s2_xe  <= s1_xe;
      s2_x   <= {s1_xm, 3'b000};
      s2_y   <= y_aln;
      s2_sp  <= s1_sp;
      s2_inv <= s1_inv;
      s2_res <= s1_res;
    end
  end

  logic [SW-1:0]  sum;
  logic [LZW-1:0] lzc;

  assign sum = (s2_xs ^ s2_ys) ? ({1'b0, s2_x} - {1'b0, s2_y}) : ({1'b0, s2_x} + {1'b0, s2_y});

  // Leading-zero count of the sum below the carry bit; an all-zero sum counts AW.
  always_comb begin
    lzc = LZW'(AW);
    for (int i = 0; i < AW; i++) begin
      if (sum[i]) lzc = LZW'(AW - 1 - i);
    end
  end

  logic             s3_sign, s3_zsign, s3_sp, s3_inv;
  logic [EXP_W-1:0] s3_xe;
  logic [SW-1:0]    s3_sum;
  logic [LZW-1:0]   s3_lzc;
  logic [W-1:0]     s3_res;

  // Stage 3 register: magnitude sum (never negative since X >= Y) and its leading-zero count.
  always_ff @(posedge clk) begin
    if (en) begin
      s3_sign  <= s2_xs;
      s3_zsign <= s2_xs & s2_ys;
      s3_xe    <= s2_xe;
      s3_sum   <= sum;
      s3_lzc   <= lzc;
      s3_sp    <= s2_sp;
      s3_inv   <= s2_inv;
      s3_res   <= s2_res;
    end
  end

  int            e_norm;
  logic [AW-1:0] norm;

  // Normalise: one step right on carry-out keeping sticky, otherwise left by the leading-zero count.
  always_comb begin
    if (s3_sum[SW-1]) begin
      norm   = {s3_sum[SW-1:2], |s3_sum[1:0]};
      e_norm = int'(s3_xe) + 1;
    end else begin
      norm   = s3_sum[AW-1:0] << s3_lzc;
      e_norm = int'(s3_xe) - int'(s3_lzc);
    end
  end

  logic             s4_sign, s4_zsign, s4_uf, s4_sp, s4_inv;
  logic [EXP_W:0]   s4_exp;
  logic [AW-1:0]    s4_norm;
  logic [W-1:0]     s4_res;

  // Stage 4 register: normalised mantissa; a cleared hidden bit means the sum was exactly zero.
  always_ff @(posedge clk) begin
    if (en) begin
      s4_sign  <= s3_sign;
      s4_zsign <= s3_zsign;
      s4_uf    <= (e_norm <= 0);
      s4_exp   <= e_norm[EXP_W:0];
      s4_norm  <= norm;
      s4_sp    <= s3_sp;
      s4_inv   <= s3_inv;
      s4_res   <= s3_res;
    end
  end

  logic [MAN_W:0] mant;
  logic [2:0]     grs;
  logic [W-1:0]   o_res;
  logic [3:0]     o_flags;
`ifdef FP_ADDSUB_RNE_EN
  logic             rup;
  logic [MAN_W+1:0] mr;
  logic [EXP_W+1:0] e_r;
`endif

  assign mant = s4_norm[AW-1:3];
  assign grs  = s4_norm[2:0];

  // Round, pack and flag; special results take priority, then exact zero, then flush-to-zero.
  always_comb begin
    o_res   = '0;
    o_flags = '0;
`ifdef FP_ADDSUB_RNE_EN
    rup = grs[2] & (grs[1] | grs[0] | mant[0]);
    mr  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rup};
    e_r = {1'b0, s4_exp} + {{(EXP_W+1){1'b0}}, mr[MAN_W+1]};
`endif
    if (s4_sp) begin
      o_res   = s4_res;
      o_flags = {s4_inv, 3'b000};
    end else if (!mant[MAN_W]) begin
      o_res = {s4_zsign, {(W-1){1'b0}}};
    end else if (s4_uf) begin
      o_res   = {s4_sign, {(W-1){1'b0}}};
      o_flags = 4'b0011;
`ifdef FP_ADDSUB_RNE_EN
    end else if (e_r >= {2'b00, EMAX}) begin
      o_res   = {s4_sign, EMAX, {MAN_W{1'b0}}};
      o_flags = 4'b0101;
    end else begin
      o_res   = {s4_sign, e_r[EXP_W-1:0], mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0]};
      o_flags = {3'b000, |grs};
    end
`else
    end else if (s4_exp >= {1'b0, EMAX}) begin
      o_res   = {s4_sign, EMAXM1, {MAN_W{1'b1}}};
      o_flags = 4'b0101;
    end else begin
      o_res   = {s4_sign, s4_exp[EXP_W-1:0], mant[MAN_W-1:0]};
      o_flags = {3'b000, |grs};
    end
`endif
  end

  // Valid chain and output register; everything holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      out_valid <= v4;
      if (v4) begin
        result <= o_res;
        flags  <= o_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors for fp_addsub_pipe in binary32 form, both rounding builds.
module tb_fp_addsub_pipe;
  logic        clk, rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int          checks = 0;
  int          errors = 0;

`ifdef FP_ADDSUB_RNE_EN
  localparam logic [31:0] EXP_GT_HALF = 32'h3F800001;
  localparam logic [31:0] EXP_ROUND_C = 32'h40000000;
  localparam logic [31:0] EXP_OVF     = 32'h7F800000;
`else
  localparam logic [31:0] EXP_GT_HALF = 32'h3F800000;
  localparam logic [31:0] EXP_ROUND_C = 32'h3FFFFFFF;
  localparam logic [31:0] EXP_OVF     = 32'h7F7FFFFF;
`endif

  logic [31:0] stream_a   [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                  32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] stream_exp [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000};

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                               input logic ts, input logic [31:0] er, input logic [3:0] ef);
    int lat;
    @(negedge clk);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'd4);
    checkOutput({tag, ".result"}, result, er);
    checkOutput({tag, ".flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent, got, seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.result", result, 32'd0);
    checkOutput("reset.flags", 32'(flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);

    applyStimulus("one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    applyStimulus("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    applyStimulus("above_half",    32'h3F800000, 32'h33C00000, 1'b0, EXP_GT_HALF,  4'b0001);
    applyStimulus("round_carry",   32'h3FFFFFFF, 32'h33800000, 1'b0, EXP_ROUND_C,  4'b0001);
    applyStimulus("cancel",        32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000);
    applyStimulus("neg_zeros",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    applyStimulus("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, EXP_OVF,      4'b0101);
    applyStimulus("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    applyStimulus("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    applyStimulus("neg_inf_sub",   32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    applyStimulus("snan",          32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    applyStimulus("qnan",          32'h7FC00001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b0000);
    applyStimulus("underflow",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    applyStimulus("subnormal_in",  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    applyStimulus("one_minus_half",32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'b0000);
    applyStimulus("neg_two_plus1", 32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000);

    repeat (2) @(negedge clk);
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 6) begin
        in_valid = 1'b1; a = stream_a[sent]; b = 32'h3F800000; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (out_ready) begin
          checkOutput("stream.result", result, stream_exp[got]);
          got++;
        end else begin
          checkOutput("stall.hold", result, stream_exp[got]);
          checkOutput("stall.in_ready", 32'(in_ready), 32'd0);
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checkOutput("stream.count", 32'(got), 32'd6);

    repeat (2) @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst.result", result, 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("rst.flush", 32'(seen), 32'd0);
    applyStimulus("after_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
